// File: rtl/min_9bit.sv
// min_9bit: registered minimum of two 9-bit sign-magnitude operands.
// One-cycle latency, back-to-back capable, asynchronous active-low reset.
module min_9bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [8:0] inputA,
  input  logic [8:0] inputB,
  output logic [8:0] out,
  output logic       out_valid,
  output logic       sel_b
);

  logic [7:0] mag_a;
  logic [7:0] mag_b;
  logic       neg_a;
  logic       neg_b;
  logic       pick_b;

  assign mag_a = inputA[7:0];
  assign mag_b = inputB[7:0];

  // -0 carries no weight: a zero magnitude is never treated as negative
  assign neg_a = inputA[8] & (mag_a != 8'd0);
  assign neg_b = inputB[8] & (mag_b != 8'd0);

  // Ties, including +0/-0 pairs, fall through to A
  always_comb begin
    pick_b = 1'b0;
    unique case (1'b1)
      neg_a & ~neg_b:  pick_b = 1'b0;
      ~neg_a & neg_b:  pick_b = 1'b1;
      neg_a & neg_b:   pick_b = mag_b > mag_a;
      ~neg_a & ~neg_b: pick_b = mag_b < mag_a;
      default:         pick_b = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 9'd0;
      sel_b     <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      out       <= pick_b ? inputB : inputA;
      sel_b     <= pick_b;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_min_9bit.sv
// tb_min_9bit: scoreboard bench for min_9bit.
// Directed vectors, handshake, async reset and random pairs.
module tb_min_9bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [8:0] inputA;
  logic [8:0] inputB;
  logic [8:0] out;
  logic       out_valid;
  logic       sel_b;

  typedef struct packed {
    logic [8:0] o;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   total;
  int   bad;

  min_9bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .inputA(inputA),
    .inputB(inputB),
    .out(out),
    .out_valid(out_valid),
    .sel_b(sel_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sm_val(input logic [8:0] v);
    int m;
    m = int'(v[7:0]);
    return v[8] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [8:0] a, input logic [8:0] b);
    exp_t e;
    e.s = sm_val(b) < sm_val(a);
    e.o = e.s ? b : a;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [8:0] a,
                       input logic [8:0] b, input exp_t e);
    @(negedge clk);
    in_valid = v;
    inputA   = a;
    inputB   = b;
    if (v) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out !== 9'd0 || sel_b !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%b sel_b=%b out_valid=%b want 0/0/0",
               out, sel_b, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [8:0] ta[11];
    logic [8:0] tb[11];
    logic [8:0] to[11];
    logic       ts[11];
    exp_t e;
    exp_t g;
    ta = '{9'h101, 9'd3, 9'd3, 9'h103, 9'h103, 9'h100,
           9'd0, 9'h17f, 9'h0ff, 9'h1ff, 9'h0ff};
    tb = '{9'd0, 9'd2, 9'h102, 9'd2, 9'h102, 9'd0,
           9'h100, 9'h17f, 9'h1ff, 9'h1fe, 9'h0fe};
    to = '{9'h101, 9'd2, 9'h102, 9'h103, 9'h103, 9'h100,
           9'd0, 9'h17f, 9'h1ff, 9'h1ff, 9'h0fe};
    ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 11; i++) begin
      e.o = to[i];
      e.s = ts[i];
      drive(1'b1, ta[i], tb[i], e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || out !== g.o || sel_b !== g.s) begin
        bad++;
        $display("FAIL vector%0d: out=%b sel_b=%b v=%b want %b/%b/1",
                 i, out, sel_b, out_valid, g.o, g.s);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] pa[4];
    logic [8:0] pb[4];
    exp_t g;
    pa = '{9'd7, 9'h105, 9'd0, 9'h1c8};
    pb = '{9'd9, 9'd4, 9'h100, 9'h1c9};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pa[i], pb[i], model(pa[i], pb[i]));
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      last_exp = g;
      total++;
      if (out_valid !== 1'b1 || out !== g.o || sel_b !== g.s) begin
        bad++;
        $display("FAIL stream%0d: out=%b sel_b=%b v=%b want %b/%b/1",
                 i, out, sel_b, out_valid, g.o, g.s);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 9'bx, 9'bx, last_exp);
      @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || out !== last_exp.o ||
          sel_b !== last_exp.s) begin
        bad++;
        $display("FAIL idle%0d: out=%b sel_b=%b v=%b want %b/%b/0",
                 i, out, sel_b, out_valid, last_exp.o, last_exp.s);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t g;
    drive(1'b1, 9'd200, 9'h1ff, model(9'd200, 9'h1ff));
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    total++;
    if (out_valid !== 1'b1 || out !== g.o || sel_b !== g.s) begin
      bad++;
      $display("FAIL pre_rst: out=%b sel_b=%b v=%b want %b/%b/1",
               out, sel_b, out_valid, g.o, g.s);
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 9'd0 || sel_b !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: out=%b sel_b=%b v=%b want 0/0/0",
               out, sel_b, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 9'h180, 9'd1, model(9'h180, 9'd1));
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    last_exp = g;
    total++;
    if (out_valid !== 1'b1 || out !== g.o || sel_b !== g.s) begin
      bad++;
      $display("FAIL post_rst: out=%b sel_b=%b v=%b want %b/%b/1",
               out, sel_b, out_valid, g.o, g.s);
    end
  endtask

  task automatic test_random();
    int         pairs;
    logic       v;
    logic [8:0] a;
    logic [8:0] b;
    exp_t       g;
    pairs = 0;
    while (pairs < 10000) begin
      v = $urandom_range(0, 7) != 0;
      a[8] = $urandom_range(0, 1);
      b[8] = $urandom_range(0, 1);
      a[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                           : 8'($urandom_range(0, 255));
      b[7:0] = ($urandom_range(0, 3) == 0) ? a[7:0]
                                           : 8'($urandom_range(0, 255));
      drive(v, v ? a : 9'bx, v ? b : 9'bx, model(a, b));
      @(posedge clk);
      #1;
      if (v) begin
        pairs++;
        g = exp_q.pop_front();
        last_exp = g;
      end
      total++;
      if (out_valid !== v || out !== last_exp.o ||
          sel_b !== last_exp.s) begin
        bad++;
        $display("FAIL rand%0d: out=%b sel_b=%b v=%b want %b/%b/%b",
                 pairs, out, sel_b, out_valid, last_exp.o, last_exp.s, v);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inputA   = 9'd0;
    inputB   = 9'd0;
    last_exp = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue: left=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/min_9bit.md
# min_9bit

Registered minimum selector for two 9-bit sign-magnitude operands, part of the 9-bit ALU datapath. On each rising clock edge it samples `inputA` and `inputB` when `in_valid` is high. One cycle later it presents the numerically smaller operand on `out`, together with `out_valid` and a source flag. The block drives the ALU's MIN operation and feeds the result mux downstream.

## Interface
Parameters: none. Width is fixed at 9 bits: bit 8 is the sign (1 = negative), bits 7:0 are the magnitude.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: operands on `inputA`/`inputB` are valid this cycle.
- `inputA` input 9: operand A, sign-magnitude.
- `inputB` input 9: operand B, sign-magnitude.
- `out` output 9: registered minimum, sign-magnitude, bit-exact copy of the selected operand.
- `out_valid` output 1: `out` holds a result computed from the operands sampled on the previous edge.
- `sel_b` output 1: 1 = `out` was taken from `inputB`, 0 = taken from `inputA`.

## Operation
Notation: sA/sB are the sign bits, mA/mB are the 8-bit magnitudes. Comparison is purely combinational on the sampled inputs.

Selection rules, applied in this order:
- **Both magnitudes zero** (any signs, so +0, -0 mixes): treat as equal and select A.
- **Signs differ:** select the operand with sign = 1. Exception: if the negative operand has magnitude 0, compare as +0 against the other positive value, so -0 vs +5 selects -0 (0 < 5).
- **Both positive (sA = sB = 0):** select the smaller magnitude.
- **Both negative (sA = sB = 1):** select the larger magnitude.
- **Ties (equal value):** select A.
- **Zero check:** a value whose magnitude is 0 is zero regardless of sign. Zero is less than any positive nonzero value and greater than any negative nonzero value.

Result handling:
- `out` is the selected operand copied unmodified; -0 is not normalised.
- No arithmetic is performed; no overflow or saturation is possible.

Design decision: `-0` and `+0` compare equal, with A winning the tie.

## Timing
Latency:
- Fixed at 1 cycle: operands sampled at edge N appear on `out`/`sel_b` after edge N.
- `out_valid` is asserted for exactly that cycle.
- Throughput is 1 result per cycle; back-to-back `in_valid` is allowed.

When `in_valid` is 0 at an edge:
- `out` and `sel_b` hold their previous values.
- `out_valid` goes to 0.

Reset:
- Asserting `rst_n` low asynchronously forces `out` = 9'b0, `sel_b` = 0 and `out_valid` = 0 immediately, regardless of `clk`.
- Deassertion is synchronised by the consumer. The first edge with `rst_n` high and `in_valid` high produces a result on the following cycle.
- A reset mid-stream discards any result in flight; no result is emitted for operands sampled in the reset-release cycle if `rst_n` is still low at that edge.
- X on inputs while `in_valid` is 0 has no effect on outputs.

## Test plan
- **Reference vectors.** Drive each pair with `in_valid` = 1, one per cycle, and check one cycle later:
  - A = 9'b100000001 (-1), B = 0 -> `out` = 9'b100000001, `sel_b` = 0.
  - A = 3, B = 2 -> `out` = 9'b000000010, `sel_b` = 1.
  - A = 3, B = 9'b100000010 (-2) -> `out` = 9'b100000010, `sel_b` = 1.
  - A = 9'b100000011 (-3), B = 2 -> `out` = 9'b100000011, `sel_b` = 0.
  - A = -3, B = -2 -> `out` = 9'b100000011, `sel_b` = 0.
- **Zero and tie cases:**
  - A = 9'b100000000 (-0), B = 0 -> `out` = 9'b100000000, `sel_b` = 0.
  - A = 0, B = -0 -> `out` = 0, `sel_b` = 0.
  - A = B = 9'b101111111 -> `sel_b` = 0.
- **Extremes:**
  - A = 9'b011111111 (+255), B = 9'b111111111 (-255) -> `out` = 9'b111111111.
  - A = -255, B = -254 -> `out` = -255.
  - A = +255, B = +254 -> `out` = +254.
- **Handshake:** stream 4 pairs back-to-back, then drop `in_valid` for 2 cycles.
  - `out_valid` is high for exactly 4 cycles, each result arriving 1 cycle after its input.
  - `out` holds the 4th result while `out_valid` = 0.
- **Asynchronous reset:** pulse `rst_n` low between clock edges while `out_valid` = 1.
  - `out` = 0, `sel_b` = 0 and `out_valid` = 0 immediately, without waiting for an edge.
  - After release, a new pair produces its correct result 1 cycle later.
- **Randomized check:** 10k random pairs against a reference model that converts both operands to signed integers (-0 = 0, A wins ties) -> every `out`/`sel_b` matches.
